btb_assoc: RTL and testbench
============================

BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: PC/target width.
REQ-002 SHALL have parameter SETS, default 256: number of sets; power of two, at least 2.
REQ-003 SHALL have parameter WAYS, default 2: associativity; 1, 2 or 4.
REQ-004 SHALL have parameter RAS_DEPTH, default 8: return stack entries; power of two.
REQ-005 SHALL have a single clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports, in this order:
- CLK in 1: clock.
- RST in 1: async active-high reset.
- PC in ADDR_WIDTH: fetch PC to predict.
- CACHE_READY in 1: pipeline advance qualifier.
- CACHE_READY_DATA in 1: pipeline advance qualifier.
- EX_PC in ADDR_WIDTH: resolving branch PC.
- BRANCH in 1: EX holds a branch/jump.
- BRANCH_TAKEN in 1: EX branch taken.
- BRANCH_ADDR in ADDR_WIDTH: EX resolved target.
- PREDICTED in 1: EX branch was predicted correctly.
- FLUSH in 1: EX instruction squashed.
- CALL in 1: EX branch is a call.
- RETURN in 1: EX branch is a return.
- PRD_VALID out 1: prediction valid.
- PRD_ADDR out ADDR_WIDTH: next fetch address.
- BR_CNT out 32: resolved branch count.
- MISS_CNT out 32: mispredict count.

Function
REQ-007 SHALL define adv = CACHE_READY & CACHE_READY_DATA; when adv=1, EX inputs are captured into a one-stage register "r_*" on the rising edge of CLK; otherwise r_* holds.
REQ-008 SHALL take the set index from PC[log2(SETS)+1:2] and the tag from PC[ADDR_WIDTH-1:log2(SETS)+2]; the same slicing SHALL apply to r_ex_pc.
REQ-009 SHALL perform lookup combinationally with zero latency: hit = any way with valid=1 and a matching tag; WAYS=1 SHALL behave as direct-mapped.
REQ-010 SHALL drive PRD_ADDR with the following priority:
- r_branch & r_taken & !r_predicted: r_branch_addr.
- r_branch & !r_predicted: r_ex_pc+4.
- lookup hit with counter[1]=1: the hit way's target.
- otherwise: PC+4.
All additions SHALL wrap modulo 2^ADDR_WIDTH.
REQ-011 SHALL drive PRD_VALID = !RST.
REQ-012 SHALL apply updates one cycle after capture, when r_branch & adv & !r_flush.
REQ-013 SHALL handle an update hit as follows: the 2-bit counter saturates, +1 if taken, -1 if not; if taken and the stored target differs, the target is rewritten.
REQ-014 SHALL handle an update miss as follows:
- Taken: allocate the lowest-index invalid way, else the set's round-robin victim; write tag and target, set counter=2'b10, then advance that set's round-robin pointer (wraps at WAYS).
- Not taken: no allocation.
REQ-015 SHALL increment BR_CNT on each applied update, and increment MISS_CNT when the applied update also has !r_predicted; both counters wrap at 2^32.
REQ-016 SHALL update only the entry being updated when a lookup and an update target the same set in the same cycle; the lookup SHALL see pre-update contents.
REQ-017 SHALL freeze r_*, the arrays and the counters whenever adv=0.

Reset
REQ-018 SHALL, on RST, asynchronously clear all valid bits, counters, round-robin pointers, r_* registers, BR_CNT, MISS_CNT and the RAS pointer and occupancy; tag and target arrays SHALL NOT be reset.
REQ-019 SHALL keep PRD_VALID=0 and PRD_ADDR=PC+4 while RST=1, and SHALL discard an update in flight when RST is asserted mid-operation.

Configuration
REQ-020 SHALL, with macro BTB_RAS_EN defined, keep a RAS_DEPTH stack:
- An applied update with r_call pushes r_ex_pc+4.
- An applied update with r_return pops.
- Call and return together replace the top entry.
- Push when full overwrites the oldest entry; pop when empty is ignored.
- Each entry stores an is_ret bit; a hit with is_ret=1 and a non-empty stack SHALL predict the top of stack, ahead of the counter.
REQ-021 SHALL, without BTB_RAS_EN, leave CALL and RETURN present but ignored, with no stack and no is_ret storage.

Structure
REQ-022 SHALL place the counter encodings, the index and tag width functions and the default parameters in package btb_pkg.
REQ-023 SHALL implement the stack as sub-module btb_ras, instantiated only under BTB_RAS_EN.

Verification
REQ-024 SHALL cover these directed scenarios:
- Taken branch at 0x100, target 0x400, PREDICTED=0: next cycle PRD_ADDR=0x400; later PC=0x100 gives PRD_ADDR=0x400.
- Same branch resolved not-taken twice: PC=0x100 gives PRD_ADDR=0x104.
- WAYS=2, SETS=256: taken branches at 0x100, 0x500, 0x900 (same set): the third evicts 0x100; 0x500 and 0x900 still hit.
- FLUSH=1 on a taken branch: no allocation; BR_CNT unchanged.
- adv=0 for 5 cycles with BRANCH=1: counters and arrays unchanged; RST pulsed mid-update: all lookups miss afterwards, BR_CNT=0.
- BTB_RAS_EN: call at 0x200, then return entry hit: PRD_ADDR=0x204; 9 pushes into RAS_DEPTH=8 followed by 8 pops return the newest 8 addresses.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: default parameters,
// 2-bit counter encodings and index/tag width helpers.
package btb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SETS       = 256;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_RAS_DEPTH  = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  // Tag covers everything above the set index and the word offset.
  function automatic int tag_width(input int addr_width, input int sets);
    return addr_width - $clog2(sets) - 2;
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? c : 2'(c + 2'd1);
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? c : 2'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_ras.sv
// Circular return-address stack; a push into a full stack overwrites the
// oldest entry, a pop from an empty stack is ignored.
module btb_ras
  import btb_pkg::*;
#(
  parameter int DEPTH = DEF_RAS_DEPTH,
  parameter int AW    = DEF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr_q;   // next free slot; top lives one below
  logic [PW:0]   cnt_q;
  logic [PW-1:0] top_idx;
  logic          replace;
  logic          push_only;
  logic          pop_only;

  assign top_idx   = ptr_q - 1'b1;
  assign empty     = (cnt_q == '0);
  assign top       = mem[top_idx];
  assign replace   = push & pop & ~empty;
  assign push_only = push & ~replace;
  assign pop_only  = pop & ~push & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_only) begin
      ptr_q <= ptr_q + 1'b1;
      if (cnt_q != (PW+1)'(DEPTH)) cnt_q <= cnt_q + 1'b1;
    end else if (pop_only) begin
      ptr_q <= ptr_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (replace) mem[top_idx] <= push_data;
    else if (push_only) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit counters, round-robin replacement and
// zero-latency lookup. Define BTB_RAS_EN to add the return-address stack.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic                  BRANCH,
  input  logic                  BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  input  logic                  PREDICTED,
  input  logic                  FLUSH,
  input  logic                  CALL,
  input  logic                  RETURN,
  output logic                  PRD_VALID,
  output logic [ADDR_WIDTH-1:0] PRD_ADDR,
  output logic [31:0]           BR_CNT,
  output logic [31:0]           MISS_CNT
);

  localparam int IW = idx_width(SETS);
  localparam int TW = tag_width(ADDR_WIDTH, SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                  valid_q [SETS][WAYS];
  logic [1:0]            ctr_q   [SETS][WAYS];
  logic [TW-1:0]         tag_q   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] tgt_q   [SETS][WAYS];
  logic [WW-1:0]         rr_q    [SETS];

  logic                  r_branch, r_taken, r_predicted, r_flush;
  logic [ADDR_WIDTH-1:0] r_ex_pc, r_branch_addr;

  logic                  adv, upd;
  logic [IW-1:0]         idx, u_idx;
  logic [TW-1:0]         tag, u_tag;
  logic                  hit, u_hit, inv_found;
  logic [WW-1:0]         hit_way, u_way, inv_way, alloc_way;
  logic                  use_ras;
  logic [ADDR_WIDTH-1:0] ras_top;

  assign adv       = CACHE_READY & CACHE_READY_DATA;
  assign upd       = r_branch & adv & ~r_flush;
  assign idx       = PC[IW+1:2];
  assign tag       = PC[ADDR_WIDTH-1:IW+2];
  assign u_idx     = r_ex_pc[IW+1:2];
  assign u_tag     = r_ex_pc[ADDR_WIDTH-1:IW+2];
  assign alloc_way = inv_found ? inv_way : rr_q[u_idx];
  assign PRD_VALID = ~RST;

  // Descending scans so the lowest matching way wins.
  always_comb begin
    hit = 1'b0; hit_way = '0;
    u_hit = 1'b0; u_way = '0;
    inv_found = 1'b0; inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit = 1'b1; hit_way = WW'(w);
      end
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1; u_way = WW'(w);
      end
      if (!valid_q[u_idx][w]) begin
        inv_found = 1'b1; inv_way = WW'(w);
      end
    end
  end

  always_comb begin
    if (r_branch && r_taken && !r_predicted) PRD_ADDR = r_branch_addr;
    else if (r_branch && !r_predicted)       PRD_ADDR = r_ex_pc + ADDR_WIDTH'(4);
    else if (use_ras)                        PRD_ADDR = ras_top;
    else if (hit && ctr_q[idx][hit_way][1])  PRD_ADDR = tgt_q[idx][hit_way];
    else                                     PRD_ADDR = PC + ADDR_WIDTH'(4);
  end

`ifdef BTB_RAS_EN
  logic r_call, r_return, ras_empty;
  logic is_ret_q [SETS][WAYS];

  btb_ras #(.DEPTH(RAS_DEPTH), .AW(ADDR_WIDTH)) u_ras (
    .clk(CLK), .rst(RST),
    .push(upd & r_call), .pop(upd & r_return),
    .push_data(r_ex_pc + ADDR_WIDTH'(4)),
    .top(ras_top), .empty(ras_empty)
  );
  assign use_ras = hit & is_ret_q[idx][hit_way] & ~ras_empty;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = CALL ^ RETURN;
  assign use_ras = 1'b0;
  assign ras_top = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_branch <= 1'b0; r_taken <= 1'b0; r_predicted <= 1'b0; r_flush <= 1'b0;
      r_ex_pc <= '0; r_branch_addr <= '0;
`ifdef BTB_RAS_EN
      r_call <= 1'b0; r_return <= 1'b0;
`endif
    end else if (adv) begin
      r_branch <= BRANCH; r_taken <= BRANCH_TAKEN; r_predicted <= PREDICTED;
      r_flush <= FLUSH; r_ex_pc <= EX_PC; r_branch_addr <= BRANCH_ADDR;
`ifdef BTB_RAS_EN
      r_call <= CALL; r_return <= RETURN;
`endif
    end
  end

  // Valid bits, counters, round-robin pointers and statistics.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BR_CNT <= '0; MISS_CNT <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= CTR_SNT;
        end
      end
    end else if (upd) begin
      BR_CNT <= BR_CNT + 32'd1;
      if (!r_predicted) MISS_CNT <= MISS_CNT + 32'd1;
      if (u_hit) begin
        ctr_q[u_idx][u_way] <= r_taken ? ctr_inc(ctr_q[u_idx][u_way])
                                       : ctr_dec(ctr_q[u_idx][u_way]);
      end else if (r_taken) begin
        valid_q[u_idx][alloc_way] <= 1'b1;
        ctr_q[u_idx][alloc_way]   <= CTR_WT;
        rr_q[u_idx] <= (rr_q[u_idx] == WW'(WAYS - 1)) ? '0 : rr_q[u_idx] + 1'b1;
      end
    end
  end

  // Payload arrays carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (upd) begin
      if (u_hit) begin
        if (r_taken && tgt_q[u_idx][u_way] != r_branch_addr)
          tgt_q[u_idx][u_way] <= r_branch_addr;
`ifdef BTB_RAS_EN
        is_ret_q[u_idx][u_way] <= r_return;
`endif
      end else if (r_taken) begin
        tag_q[u_idx][alloc_way] <= u_tag;
        tgt_q[u_idx][alloc_way] <= r_branch_addr;
`ifdef BTB_RAS_EN
        is_ret_q[u_idx][alloc_way] <= r_return;
`endif
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: drivers push expected outputs into a queue,
// a negedge monitor pops and compares. RAS cases build with BTB_RAS_EN.
module tb_btb_assoc;

  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] PC, EX_PC, BRANCH_ADDR;
  logic          CACHE_READY, CACHE_READY_DATA;
  logic          BRANCH, BRANCH_TAKEN, PREDICTED, FLUSH, CALL, RETURN;
  logic          PRD_VALID;
  logic [AW-1:0] PRD_ADDR;
  logic [31:0]   BR_CNT, MISS_CNT;

  btb_assoc #(.ADDR_WIDTH(AW), .SETS(256), .WAYS(2), .RAS_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .PC(PC),
    .CACHE_READY(CACHE_READY), .CACHE_READY_DATA(CACHE_READY_DATA),
    .EX_PC(EX_PC), .BRANCH(BRANCH), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_ADDR(BRANCH_ADDR), .PREDICTED(PREDICTED), .FLUSH(FLUSH),
    .CALL(CALL), .RETURN(RETURN),
    .PRD_VALID(PRD_VALID), .PRD_ADDR(PRD_ADDR),
    .BR_CNT(BR_CNT), .MISS_CNT(MISS_CNT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: entry = {kind, value}; kind 0 addr, 1 valid, 2 br_cnt, 3 miss_cnt
  logic [33:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [33:0] mon_e;
  logic [31:0] mon_act;
  string       mon_name;

  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      mon_e    = exp_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_e[33:32])
        2'd0:    mon_act = PRD_ADDR;
        2'd1:    mon_act = {31'd0, PRD_VALID};
        2'd2:    mon_act = BR_CNT;
        default: mon_act = MISS_CNT;
      endcase
      checks++;
      if (mon_act !== mon_e[31:0]) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name, mon_act, mon_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_val(input logic [1:0] kind, input logic [31:0] v, input string nm);
    exp_q.push_back({kind, v});
    name_q.push_back(nm);
  endtask

  task automatic exp_cnt(input logic [31:0] br, input logic [31:0] miss, input string nm);
    expect_val(2'd2, br, {nm, "_br_cnt"});
    expect_val(2'd3, miss, {nm, "_miss_cnt"});
  endtask

  task automatic check_pc(input logic [AW-1:0] pc, input logic [AW-1:0] exp, input string nm);
    PC = pc;
    expect_val(2'd0, exp, nm);
    step();
  endtask

  // Presents one EX branch for a single capture edge, then clears it.
  task automatic branch_cycle(input logic [AW-1:0] pc, input logic taken,
                              input logic [AW-1:0] target, input logic pred,
                              input logic flush, input logic call, input logic ret);
    EX_PC = pc; BRANCH = 1'b1; BRANCH_TAKEN = taken; BRANCH_ADDR = target;
    PREDICTED = pred; FLUSH = flush; CALL = call; RETURN = ret;
    step();
    BRANCH = 1'b0; BRANCH_TAKEN = 1'b0; PREDICTED = 1'b0;
    FLUSH = 1'b0; CALL = 1'b0; RETURN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; PC = 32'h40; EX_PC = '0; BRANCH_ADDR = '0;
    CACHE_READY = 1'b1; CACHE_READY_DATA = 1'b1;
    BRANCH = 1'b0; BRANCH_TAKEN = 1'b0; PREDICTED = 1'b0;
    FLUSH = 1'b0; CALL = 1'b0; RETURN = 1'b0;

    // reset state
    expect_val(2'd1, 32'd0, "reset_valid");
    exp_cnt(32'd0, 32'd0, "reset");
    check_pc(32'h40, 32'h44, "reset_addr");
    step();
    RST = 1'b0;
    expect_val(2'd1, 32'd1, "valid_after_reset");
    check_pc(32'h2000, 32'h2004, "cold_miss");

    // taken branch 0x100 -> 0x400, mispredicted
    branch_cycle(32'h100, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc(32'h2000, 32'h400, "redirect_taken");
    exp_cnt(32'd1, 32'd1, "after_alloc");
    check_pc(32'h100, 32'h400, "hit_taken");

    // resolved not-taken twice (second one predicted)
    branch_cycle(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc(32'h2000, 32'h104, "redirect_fallthrough");
    branch_cycle(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_pc(32'h100, 32'h104, "weak_not_taken");
    exp_cnt(32'd3, 32'd2, "after_not_taken");
    check_pc(32'h100, 32'h104, "strong_not_taken");

    // three taken branches in set 0x50; the third evicts the first
    branch_cycle(32'h140, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    branch_cycle(32'h540, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    branch_cycle(32'h940, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    exp_cnt(32'd6, 32'd5, "after_evict");
    check_pc(32'h140, 32'h144, "evicted_miss");
    check_pc(32'h540, 32'h2000, "way_hit_540");
    check_pc(32'h940, 32'h3000, "way_hit_940");
    branch_cycle(32'h140, 1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check_pc(32'h540, 32'h544, "rr_evict_540");
    check_pc(32'h940, 32'h3000, "rr_keep_940");
    check_pc(32'h140, 32'h1000, "rr_realloc_140");

    // target rewrite on a predicted taken hit
    branch_cycle(32'h940, 1'b1, 32'h3300, 1'b1, 1'b0, 1'b0, 1'b0); step();
    exp_cnt(32'd8, 32'd6, "after_rewrite");
    check_pc(32'h940, 32'h3300, "target_rewrite");

    // flushed taken branch: no allocation, no count
    branch_cycle(32'h180, 1'b1, 32'h4000, 1'b0, 1'b1, 1'b0, 1'b0); step();
    exp_cnt(32'd8, 32'd6, "after_flush");
    check_pc(32'h180, 32'h184, "flush_no_alloc");

    // adv=0 with BRANCH held high: nothing captured
    CACHE_READY = 1'b0;
    EX_PC = 32'h1C0; BRANCH = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_ADDR = 32'h5000;
    for (int i = 0; i < 5; i++) begin
      exp_cnt(32'd8, 32'd6, "stall_in");
      check_pc(32'h1C0, 32'h1C4, "stall_in_addr");
    end
    BRANCH = 1'b0; BRANCH_TAKEN = 1'b0;
    CACHE_READY = 1'b1;
    check_pc(32'h1C0, 32'h1C4, "stall_release");

    // captured branch stalled before update, then reset mid-update
    branch_cycle(32'h1C0, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b0, 1'b0);
    CACHE_READY_DATA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_cnt(32'd8, 32'd6, "stall_upd");
      check_pc(32'h2000, 32'h5000, "stall_redirect_held");
    end
    RST = 1'b1;
    #1;
    expect_val(2'd1, 32'd0, "mid_reset_valid");
    exp_cnt(32'd0, 32'd0, "mid_reset");
    check_pc(32'h1C0, 32'h1C4, "mid_reset_addr");
    CACHE_READY_DATA = 1'b1;
    step();
    RST = 1'b0;
    exp_cnt(32'd0, 32'd0, "post_reset");
    check_pc(32'h100, 32'h104, "post_reset_100");
    check_pc(32'h940, 32'h944, "post_reset_940");
    check_pc(32'h140, 32'h144, "post_reset_140");
    check_pc(32'h1C0, 32'h1C4, "post_reset_1c0");
    exp_cnt(32'd0, 32'd0, "post_reset_idle");
    step();

`ifdef BTB_RAS_EN
    // return entry trained first, then a call fills the stack
    branch_cycle(32'h880, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, 1'b1); step();
    branch_cycle(32'h200, 1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 1'b0); step();
    check_pc(32'h880, 32'h204, "ras_call_ret");
    branch_cycle(32'h880, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, 1'b1); step();
    check_pc(32'h880, 32'h999, "ras_empty_fallback");
    for (int k = 0; k < 9; k++) begin
      branch_cycle(32'h1000 + 32'(16 * k), 1'b1, 32'h800, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    for (int j = 0; j < 8; j++) begin
      check_pc(32'h880, 32'h1004 + 32'(16 * (8 - j)), $sformatf("ras_pop_%0d", j));
      branch_cycle(32'h880, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
    end
    check_pc(32'h880, 32'h999, "ras_drained");
`endif

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
